au_scheduler: RTL and testbench

Two-requester scheduler for the shared W-bit add/subtract unit with status flags (CO, OVF, N, Z). Arbitrates two valid/ready operand streams with round-robin fairness and latches the winner's operands. Sequences one operation per grant through the combinational datapath and returns the registered result and flags on a single valid/ready response channel tagged with the requester ID. Sits between operand producers (lab control logic, test sequencers) and any consumer of arithmetic results.

---
 rtl/au_sched_pkg.sv | 30 +++
 rtl/au_datapath.sv | 40 ++++
 rtl/au_scheduler.sv | 128 ++++++++++++
 tb/tb_au_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/au_sched_pkg.sv
// Shared types and constants for the two-requester add/subtract scheduler.
// The build option AU_SCHED_FIXED_PRIO_EN is consumed by au_scheduler, not here.
package au_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Registered status flags travelling with a result
  typedef struct packed {
    logic co;
    logic ovf;
    logic n;
    logic z;
  } au_flags_t;

  // Round-robin tie-break: the requester that did not win last time
  function automatic logic rr_pick(input logic last_grant);
    return (last_grant == REQ0) ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/au_datapath.sv
// Combinational W-bit add/subtract with carry, signed overflow, negative and zero.
// Subtraction adds the two's complement of B, so B = 0 yields no carry.
module au_datapath
  import au_sched_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic [W-1:0] out,
  output logic         co,
  output logic         ovf,
  output logic         n,
  output logic         z
);

  logic [W-1:0] t;
  logic [W:0]   sum;

  always_comb begin
    t   = (op == OP_ADD) ? b : W'(~b + W'(1));
    sum = {1'b0, a} + {1'b0, t};
  end

  assign out = sum[W-1:0];
  assign co  = sum[W];
  assign n   = sum[W-1];
  assign z   = (sum[W-1:0] == '0);

  // Overflow compares operand signs against the result sign
  always_comb begin
    if (op == OP_ADD) begin
      ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    end else begin
      ovf = (a[W-1] != b[W-1]) && (sum[W-1] != a[W-1]);
    end
  end

endmodule

// File: rtl/au_scheduler.sv
// Round-robin scheduler for two operand streams feeding one add/subtract unit.
// Define AU_SCHED_FIXED_PRIO_EN to make requester 0 win every tie.
module au_scheduler
  import au_sched_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_out,
  output logic         rsp_co,
  output logic         rsp_ovf,
  output logic         rsp_n,
  output logic         rsp_z
);

  state_t       state_q, state_d;
  logic [W-1:0] a_q, b_q;
  logic         op_q, id_q, last_q;
  logic         grant_vld_c, grant_id_c, accept_c;
  au_flags_t    flags_q;

  logic [W-1:0] dp_out;
  logic         dp_co, dp_ovf, dp_n, dp_z;

  // Winner selection; only meaningful while IDLE
  always_comb begin
    grant_vld_c = req0_valid | req1_valid;
    grant_id_c  = REQ0;
    if (req0_valid && req1_valid) begin
`ifdef AU_SCHED_FIXED_PRIO_EN
      grant_id_c = REQ0;
`else
      grant_id_c = rr_pick(last_q);
`endif
    end else if (req1_valid) begin
      grant_id_c = REQ1;
    end
  end

  // Next state and readies; readies never look at rsp_ready
  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && grant_vld_c) begin
          accept_c   = 1'b1;
          req0_ready = (grant_id_c == REQ0);
          req1_ready = (grant_id_c == REQ1);
          state_d    = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched operands and registered response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= REQ1;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_SUB;
      id_q      <= REQ0;
      rsp_valid <= 1'b0;
      rsp_id    <= REQ0;
      rsp_out   <= '0;
      flags_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        last_q <= grant_id_c;
        id_q   <= grant_id_c;
        a_q    <= (grant_id_c == REQ0) ? req0_a  : req1_a;
        b_q    <= (grant_id_c == REQ0) ? req0_b  : req1_b;
        op_q   <= (grant_id_c == REQ0) ? req0_op : req1_op;
      end
      if (state_q == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_out   <= dp_out;
        flags_q   <= '{co: dp_co, ovf: dp_ovf, n: dp_n, z: dp_z};
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_co  = flags_q.co;
  assign rsp_ovf = flags_q.ovf;
  assign rsp_n   = flags_q.n;
  assign rsp_z   = flags_q.z;

  au_datapath #(.W(W)) u_datapath (
    .a   (a_q),
    .b   (b_q),
    .op  (op_q),
    .out (dp_out),
    .co  (dp_co),
    .ovf (dp_ovf),
    .n   (dp_n),
    .z   (dp_z)
  );

endmodule

// File: tb/tb_au_scheduler.sv
// Self-checking bench for au_scheduler: directed vectors, corner sequences and
// a randomized run against a transaction-level reference model.
module tb_au_scheduler;
  import au_sched_pkg::*;

  localparam int unsigned W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_op;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_op;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_out;
  logic         rsp_co, rsp_ovf, rsp_n, rsp_z;

  int n_checks = 0;
  int n_pass   = 0;

  au_scheduler #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_out    (rsp_out),
    .rsp_co     (rsp_co),
    .rsp_ovf    (rsp_ovf),
    .rsp_n      (rsp_n),
    .rsp_z      (rsp_z)
  );

  always #5 clk = ~clk;

  typedef struct {
    int out;
    int co;
    int ovf;
    int n;
    int z;
  } res_t;

  typedef struct {
    int id;
    int a;
    int b;
    int op;
    int out;
    int co;
    int ovf;
    int n;
    int z;
  } vec_t;

  typedef struct {
    int id;
    int a;
    int b;
    int op;
    int cyc;
  } txn_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference arithmetic from integer/signed-range reasoning
  function automatic res_t model(input int a, input int b, input int op);
    res_t r;
    int t, s, sa, sb, sr;
    t  = (op != 0) ? b : (M - b) % M;
    s  = a + t;
    sa = (a >= M / 2) ? a - M : a;
    sb = (b >= M / 2) ? b - M : b;
    sr = (op != 0) ? sa + sb : sa - sb;
    r.out = s % M;
    r.co  = (s >= M) ? 1 : 0;
    r.ovf = (sr < -(M / 2) || sr >= M / 2) ? 1 : 0;
    r.n   = (r.out >= M / 2) ? 1 : 0;
    r.z   = (r.out == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input int a, input int b, input int op);
    if (id == 0) begin
      req0_valid = v; req0_a = W'(a); req0_b = W'(b); req0_op = (op != 0);
    end else begin
      req1_valid = v; req1_a = W'(a); req1_b = W'(b); req1_op = (op != 0);
    end
  endtask

  function automatic int sel_ready(input int id);
    return (id == 0) ? int'(req0_ready) : int'(req1_ready);
  endfunction

  task automatic check_rsp(input string tag, input int id, input int out, input int co,
                           input int ovf, input int n, input int z);
    check($sformatf("%s.id", tag),  int'(rsp_id),  id);
    check($sformatf("%s.out", tag), int'(rsp_out), out);
    check($sformatf("%s.co", tag),  int'(rsp_co),  co);
    check($sformatf("%s.ovf", tag), int'(rsp_ovf), ovf);
    check($sformatf("%s.n", tag),   int'(rsp_n),   n);
    check($sformatf("%s.z", tag),   int'(rsp_z),   z);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    rsp_ready = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  function automatic int rsp_snap();
    return int'({rsp_valid, rsp_id, rsp_out, rsp_co, rsp_ovf, rsp_n, rsp_z});
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   gids[4];
    int   gcyc[4];
    int   ng;
    int   w;
    int   snap;
    txn_t q[$];
    int   pv[2], pa[2], pb[2], pop[2];
    int   last, ops, win, stall_prev, prev_snap;

    vecs[0] = '{0, 7, 1, 1, 8, 0, 1, 1, 0};
    vecs[1] = '{1, 3, 3, 0, 0, 1, 0, 0, 1};
    vecs[2] = '{0, 5, 0, 0, 5, 0, 0, 0, 0};
    vecs[3] = '{0, 8, 1, 0, 7, 1, 1, 0, 0};
    vecs[4] = '{1, 15, 1, 1, 0, 1, 0, 0, 1};
    vecs[5] = '{1, 2, 5, 0, 13, 0, 0, 1, 0};

    // Reset values; readies held low while in reset
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 1, 1, 1);
    set_req(1, 1'b1, 2, 2, 1);
    #1;
    check("rst.ready0", int'(req0_ready), 0);
    check("rst.ready1", int'(req1_ready), 0);
    cyc();
    check("rst.rsp_valid", int'(rsp_valid), 0);
    check_rsp("rst", 0, 0, 0, 0, 0, 0);
    do_reset();

    // Directed single operations
    for (int i = 0; i < 6; i++) begin
      set_req(vecs[i].id, 1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
      #1;
      w = 0;
      while (sel_ready(vecs[i].id) == 0 && w < 8) begin
        cyc();
        w++;
      end
      check($sformatf("vec%0d.accept", i), sel_ready(vecs[i].id), 1);
      cyc();
      set_req(vecs[i].id, 1'b0, $urandom_range(0, M - 1), $urandom_range(0, M - 1), 1);
      #1;
      check($sformatf("vec%0d.exec_valid", i), int'(rsp_valid), 0);
      cyc();
      check($sformatf("vec%0d.rsp_valid", i), int'(rsp_valid), 1);
      check_rsp($sformatf("vec%0d", i), vecs[i].id, vecs[i].out, vecs[i].co,
                vecs[i].ovf, vecs[i].n, vecs[i].z);
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
      #1;
      check($sformatf("vec%0d.valid_drop", i), int'(rsp_valid), 0);
      check($sformatf("vec%0d.out_kept", i), int'(rsp_out), vecs[i].out);
    end

    // Both requesters valid continuously: grant order and spacing
    do_reset();
    set_req(0, 1'b1, 3, 4, 1);
    set_req(1, 1'b1, 9, 2, 0);
    rsp_ready = 1'b1;
    #1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      if (req0_ready || req1_ready) begin
        gids[ng] = req1_ready ? 1 : 0;
        gcyc[ng] = c;
        ng++;
      end
      cyc();
    end
    check("fair.count", ng, 4);
    for (int k = 0; k < ng; k++) begin
`ifdef AU_SCHED_FIXED_PRIO_EN
      check($sformatf("fair.grant%0d", k), gids[k], 0);
`else
      check($sformatf("fair.grant%0d", k), gids[k], k % 2);
`endif
      if (k > 0) check($sformatf("fair.gap%0d", k), gcyc[k] - gcyc[k-1], 3);
    end
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc();

    // Back-pressure in RESP: everything holds, no grants
    do_reset();
    set_req(0, 1'b1, 6, 3, 1);
    #1;
    check("stall.accept", int'(req0_ready), 1);
    cyc();
    set_req(0, 1'b1, 1, 1, 0);
    set_req(1, 1'b1, 2, 2, 0);
    cyc();
    check("stall.rsp_valid", int'(rsp_valid), 1);
    check_rsp("stall", 0, 9, 0, 1, 1, 0);
    snap = rsp_snap();
    for (int k = 0; k < 5; k++) begin
      cyc();
      check($sformatf("stall.hold%0d", k), rsp_snap(), snap);
      check($sformatf("stall.ready0_%0d", k), int'(req0_ready), 0);
      check($sformatf("stall.ready1_%0d", k), int'(req1_ready), 0);
    end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    #1;
    check("stall.release_valid", int'(rsp_valid), 0);
`ifdef AU_SCHED_FIXED_PRIO_EN
    check("stall.next_ready0", int'(req0_ready), 1);
    check("stall.next_ready1", int'(req1_ready), 0);
`else
    check("stall.next_ready0", int'(req0_ready), 0);
    check("stall.next_ready1", int'(req1_ready), 1);
`endif
    cyc();
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    #1;
    check("stall.next_exec", int'(rsp_valid), 0);
    cyc();
    check("stall.next_rsp", int'(rsp_valid), 1);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;

    // Reset while in EXEC discards the operation
    do_reset();
    set_req(0, 1'b1, 5, 5, 1);
    set_req(1, 1'b1, 4, 4, 1);
    #1;
    check("rexec.first_tie", int'(req0_ready), 1);
    cyc();
    rst_n = 1'b0;
    #1;
    check("rexec.ready0_in_rst", int'(req0_ready), 0);
    check("rexec.ready1_in_rst", int'(req1_ready), 0);
    cyc();
    rst_n = 1'b1;
    #1;
    check("rexec.rsp_valid", int'(rsp_valid), 0);
    check("rexec.grant0", int'(req0_ready), 1);
    check("rexec.grant1", int'(req1_ready), 0);
    set_req(0, 1'b0, 0, 0, 0);
    set_req(1, 1'b0, 0, 0, 0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check($sformatf("rexec.no_rsp%0d", k), int'(rsp_valid), 0);
    end

    // Randomized traffic against the transaction-level model
    do_reset();
    last = 1;
    ops = 0;
    stall_prev = 0;
    prev_snap = 0;
    for (int r = 0; r < 2; r++) begin
      pv[r] = 0; pa[r] = 0; pb[r] = 0; pop[r] = 0;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (pv[r] == 0 && $urandom_range(0, 2) != 0) begin
          pv[r]  = 1;
          pa[r]  = $urandom_range(0, M - 1);
          pb[r]  = $urandom_range(0, M - 1);
          pop[r] = $urandom_range(0, 1);
        end
        set_req(r, pv[r] != 0, pa[r], pb[r], pop[r]);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
`ifdef AU_SCHED_FIXED_PRIO_EN
      win = 0;
`else
      win = (last == 0) ? 1 : 0;
`endif
      begin
        int idle, e0, e1, ev;
        idle = (q.size() == 0) ? 1 : 0;
        e0 = (idle != 0 && pv[0] != 0 && (pv[1] == 0 || win == 0)) ? 1 : 0;
        e1 = (idle != 0 && pv[1] != 0 && (pv[0] == 0 || win == 1)) ? 1 : 0;
        ev = (q.size() > 0 && c >= q[0].cyc + 2) ? 1 : 0;
        check($sformatf("rnd%0d.ready0", c), int'(req0_ready), e0);
        check($sformatf("rnd%0d.ready1", c), int'(req1_ready), e1);
        check($sformatf("rnd%0d.rsp_valid", c), int'(rsp_valid), ev);
        if (stall_prev != 0) check($sformatf("rnd%0d.hold", c), rsp_snap(), prev_snap);
        if (ev != 0 && rsp_ready) begin
          txn_t t;
          res_t m;
          t = q.pop_front();
          m = model(t.a, t.b, t.op);
          check_rsp($sformatf("rnd%0d", c), t.id, m.out, m.co, m.ovf, m.n, m.z);
        end
        if (e0 != 0 || e1 != 0) begin
          txn_t t;
          t.id = (e1 != 0) ? 1 : 0;
          t.a = pa[t.id]; t.b = pb[t.id]; t.op = pop[t.id]; t.cyc = c;
          q.push_back(t);
          last = t.id;
          ops++;
        end
        stall_prev = (ev != 0 && !rsp_ready) ? 1 : 0;
        prev_snap = rsp_snap();
      end
      if (req0_ready) pv[0] = 0;
      if (req1_ready) pv[1] = 0;
      cyc();
    end
    check("rnd.op_count_ok", (ops >= 100) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
